// File: rtl/data_memory_bank.sv
// MEM-stage data memory: byte/half/word access with lane writes, extending loads,
// misalignment reporting, a registered read path and a zero-fill init sequencer.
module data_memory_bank #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datain,
    output logic              ready,
    output logic              dvalid,
    output logic [DATA_W-1:0] dout,
    output logic              err
);

    localparam int BYTES = DATA_W / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  accept;
    logic                  illegal;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [BL-1:0]         off;
    logic [BYTES-1:0]      wr_mask;
    logic [DATA_W-1:0]     wr_data;

    // Read-stage registers: captured at the accepting edge, consumed one edge later.
    logic                  p_valid;
    logic                  p_err;
    logic [BL-1:0]         p_off;
    logic [1:0]            p_size;
    logic                  p_sext;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     shifted;
    logic [DATA_W-1:0]     load_val;

    assign ready    = (state == ST_RUN);
    assign accept   = req & ready;
    assign word_idx = addr[DEPTH_LOG2+BL-1:BL];
    assign off      = addr[BL-1:0];

    // Address bits above the word index are deliberately ignored (address wrap).
    generate
        if (ADDR_W > DEPTH_LOG2 + BL) begin : g_addr_hi
            logic addr_hi_unused;
            assign addr_hi_unused = ^addr[ADDR_W-1:DEPTH_LOG2+BL];
        end
    endgenerate

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        illegal = 1'b0;
        if (int'(size) > BL)
            illegal = 1'b1;
        else if ((int'(off) & ((1 << size) - 1)) != 0)
            illegal = 1'b1;
    end

    always_comb begin
        wr_mask = '0;
        wr_data = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i >= int'(off) && i < int'(off) + (1 << size)) begin
                wr_mask[i]        = 1'b1;
                wr_data[8*i +: 8] = datain[8*(i-int'(off)) +: 8];
            end
        end
    end

    // NOTE: the array and the read-stage datapath carry no reset; only control state
    // needs a known value, and memory contents are cleared by the INIT sequencer instead.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_INIT) begin
            mem[idx] <= '0;
        end else if (!rst && accept && we && !illegal) begin
            for (int i = 0; i < BYTES; i++)
                if (wr_mask[i])
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
        if (accept) begin
            rd_word <= mem[word_idx];
            p_off   <= off;
            p_size  <= size;
            p_sext  <= sext;
        end
    end

    always_comb begin
        int nb;
        logic sign;
        nb = 1 << p_size;
        if (nb > BYTES)
            nb = BYTES;
        shifted  = rd_word >> (8 * int'(p_off));
        sign     = shifted[8*nb-1];
        load_val = '0;
        for (int i = 0; i < BYTES; i++)
            load_val[8*i +: 8] = (i < nb) ? shifted[8*i +: 8] : {8{p_sext & sign}};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            idx     <= '0;
            p_valid <= 1'b0;
            p_err   <= 1'b0;
            dvalid  <= 1'b0;
            err     <= 1'b0;
            dout    <= '0;
        end else begin
            if (state == ST_INIT) begin
                idx <= idx + 1'b1;
                if (idx == DEPTH_LOG2'(DEPTH - 1))
                    state <= ST_RUN;
            end
            // Legal stores complete silently; loads and rejected accesses respond.
            p_valid <= accept & (~we | illegal);
            p_err   <= accept & illegal;
            dvalid  <= p_valid;
            err     <= p_err;
            if (p_valid)
                dout <= p_err ? '0 : load_val;
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// Self-checking bench for data_memory_bank: vector table driven back-to-back,
// responses matched against a scoreboard queue, plus init and mid-reset sequences.
module tb_data_memory_bank;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        ready;
    logic        dvalid;
    logic [31:0] dout;
    logic        err;

    data_memory_bank dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .size   (size),
        .sext   (sext),
        .addr   (addr),
        .datain (datain),
        .ready  (ready),
        .dvalid (dvalid),
        .dout   (dout),
        .err    (err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] data;
        logic        resp;
        logic [31:0] exp_dout;
        logic        exp_err;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] last_dout = '0;
    logic        prev_ready = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic w, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] d, input logic rsp,
                                input logic [31:0] ed, input logic ee, input string nm);
        vec_t v;
        v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.data = d;
        v.resp = rsp; v.exp_dout = ed; v.exp_err = ee; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = v.we; size = v.size; sext = v.sext; addr = v.addr; datain = v.data;
        if (v.resp) begin
            e.dout = v.exp_dout; e.err = v.exp_err; e.cyc = cyc + 2; e.name = v.name;
            sb.push_back(e);
        end
    endtask

    // Checks ready stays low for the first 63 edges after release and rises on the 64th.
    task automatic wait_init(input string name);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            check(name, ready, (i == 64) ? 1 : 0);
            if (i == 63) req = 1'b0;
        end
    endtask

    // Response monitor, sampling 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (rst) begin
            check("rst_dvalid", dvalid, 0);
            check("rst_err", err, 0);
            check("rst_dout", dout, 0);
            check("rst_ready", ready, 0);
            last_dout  = '0;
            prev_ready = 1'b0;
        end else begin
            if (prev_ready) check("ready_held", ready, 1);
            prev_ready = ready;
            if (dvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_dvalid", dvalid, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_dout"}, dout, e.dout);
                    check({e.name, "_err"}, err, e.err);
                    check({e.name, "_cycle"}, cyc, e.cyc);
                end
                last_dout = dout;
            end else begin
                check("idle_err", err, 0);
                check("dout_hold", dout, last_dout);
            end
        end
    end

    initial begin
        vec_t v;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = '0; datain = '0;

        //  we  sz   sx   addr   data         resp exp_dout      err  name
        add(0, 2'd2, 0, 32'h50,  32'h0,        1, 32'h00000000, 0, "init_clear");
        add(1, 2'd2, 0, 32'h50,  32'h000000a3, 0, 32'h0,        0, "st_w50");
        add(0, 2'd2, 0, 32'h50,  32'h0,        1, 32'h000000a3, 0, "ld_w50");
        add(0, 2'd2, 0, 32'h54,  32'h0,        1, 32'h00000000, 0, "ld_w54_b2b");
        add(1, 2'd2, 0, 32'h54,  32'h00000027, 0, 32'h0,        0, "st_w54");
        add(1, 2'd0, 0, 32'h55,  32'hffffff81, 0, 32'h0,        0, "st_b55");
        add(0, 2'd2, 0, 32'h54,  32'h0,        1, 32'h00008127, 0, "ld_w54");
        add(0, 2'd0, 1, 32'h55,  32'h0,        1, 32'hffffff81, 0, "ld_b55_sx");
        add(0, 2'd0, 0, 32'h55,  32'h0,        1, 32'h00000081, 0, "ld_b55_zx");
        add(0, 2'd1, 1, 32'h54,  32'h0,        1, 32'hffff8127, 0, "ld_h54_sx");
        add(0, 2'd0, 1, 32'h54,  32'h0,        1, 32'h00000027, 0, "ld_b54_sx");
        add(0, 2'd1, 1, 32'h56,  32'h0,        1, 32'h00000000, 0, "ld_h56_sx");
        add(1, 2'd1, 0, 32'h5b,  32'h00001234, 1, 32'h00000000, 1, "st_h5b_mis");
        add(0, 2'd2, 0, 32'h58,  32'h0,        1, 32'h00000000, 0, "ld_w58_untouched");
        add(0, 2'd2, 0, 32'h5a,  32'h0,        1, 32'h00000000, 1, "ld_w5a_mis");
        add(0, 2'd3, 0, 32'h58,  32'h0,        1, 32'h00000000, 1, "size3");
        add(1, 2'd2, 0, 32'h158, 32'h00000079, 0, 32'h0,        0, "st_w158");
        add(0, 2'd2, 0, 32'h58,  32'h0,        1, 32'h00000079, 0, "ld_w58_wrap");
        add(1, 2'd2, 0, 32'hfc,  32'h00000115, 0, 32'h0,        0, "st_wfc");
        add(0, 2'd2, 0, 32'h1fc, 32'h0,        1, 32'h00000115, 0, "ld_w1fc_wrap");
        add(1, 2'd2, 0, 32'h60,  32'h80000001, 0, 32'h0,        0, "st_w60");
        add(1, 2'd1, 0, 32'h62,  32'h0000beef, 0, 32'h0,        0, "st_h62");
        add(0, 2'd2, 1, 32'h60,  32'h0,        1, 32'hbeef0001, 0, "ld_w60_sx_ignored");
        add(0, 2'd1, 0, 32'h62,  32'h0,        1, 32'h0000beef, 0, "ld_h62_zx");
        add(0, 2'd1, 1, 32'h62,  32'h0,        1, 32'hffffbeef, 0, "ld_h62_sx");
        add(0, 2'd0, 1, 32'h63,  32'h0,        1, 32'hffffffbe, 0, "ld_b63_sx");

        repeat (2) @(negedge clk);
        check("reset_ready", ready, 0);
        check("reset_dvalid", dvalid, 0);
        check("reset_dout", dout, 0);
        rst = 1'b0;
        wait_init("init_ready");

        foreach (vecs[i]) drive(vecs[i]);
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset one edge after a load is accepted: its response must be dropped.
        req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h50;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // Requests presented during INIT must be ignored.
        wait_init("reinit_ready");

        add(0, 2'd2, 0, 32'h50, 32'h0, 1, 32'h00000000, 0, "ld_w50_after_reset");
        v = vecs[vecs.size()-1];
        drive(v);
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_bank.md
# data_memory_bank

Parametrised single-port data memory for the pipelined CPU's MEM stage. It adds byte, halfword and word access with byte-lane writes, sign- or zero-extending loads, and misalignment detection. Reads are registered, and a ready/valid handshake lets the pipeline stall on the memory. After reset, a built-in initialisation sequencer clears every word before any access is accepted.

## Interface
- `DATA_W`, default 32: word width in bits; power of two, 16–64. `BYTES = DATA_W/8`, `BL = log2(BYTES)`.
- `DEPTH_LOG2`, default 6: log2 of the number of words (`DEPTH = 2**DEPTH_LOG2`).
- `ADDR_W`, default 32: byte-address width; must be ≥ `DEPTH_LOG2 + BL`.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  1: access request, sampled only while `ready`=1.
- `we`  in  1: 1 = store, 0 = load.
- `size`  in  2: access width is `2**size` bytes; legal only when `size ≤ BL`.
- `sext`  in  1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr`  in  `ADDR_W`: byte address.
- `datain`  in  `DATA_W`: store data, right-justified (low `2**size` bytes are used).
- `ready`  out  1: block accepts a request this cycle.
- `dvalid`  out  1: one-cycle pulse marking a completed load or a rejected access.
- `dout`  out  `DATA_W`: load result, right-justified and extended.
- `err`  out  1: one-cycle pulse, qualified by `dvalid`; misaligned or illegal-size access.

## Operation
- **State machine.** Two states, INIT and RUN.
  - `rst`=1 at an edge: state ← INIT, `idx` ← 0, `dvalid`/`err`/`dout` ← 0.
  - In INIT, each edge with `rst`=0 writes 0 to word `idx` and increments `idx`. The edge that clears word `DEPTH-1` moves the state to RUN.
  - `ready` = (state == RUN), decoded combinationally from the state register.
- **Accepted access.** An access is accepted when `req` & `ready` are high at an edge. One access per cycle; no queueing. `req` while `ready`=0 is ignored: no write, no `dvalid`.
- **Word index.** `addr[DEPTH_LOG2+BL-1:BL]`. Higher address bits are ignored, so addresses wrap modulo `DEPTH*BYTES`.
- **Lane offset.** `off = addr[BL-1:0]`.
- **Legality check.** The access is illegal if `size > BL` or `off` is not a multiple of `2**size`.
  - An illegal access, load or store, leaves memory untouched.
  - The next cycle then shows `dvalid`=1, `err`=1, `dout`=0.
- **Store.** Bytes `off .. off+2**size-1` of the addressed word take the low bytes of `datain`, byte 0 going to lane `off`. The update happens at the accepting edge. Other lanes are unchanged. A legal store produces no `dvalid`.
- **Load.** The addressed word is read at the accepting edge. Lanes `off..` are shifted down to bit 0, and the upper bits are filled with the sign bit of the top selected byte when `sext`=1, otherwise with 0.
  - A full-word load ignores `sext`.
  - A load accepted the cycle after a store to the same word returns the updated data.
- **Output hold.** `dout` holds its last value while `dvalid`=0; `err` is 0 whenever `dvalid`=0.
- **Reset mid-operation.** A response due on the edge where `rst`=1 is dropped (`dvalid` stays 0). Initialisation restarts from word 0, and all prior contents are lost.

## Timing
- **Reset values.** `ready`=0, `dvalid`=0, `err`=0, `dout`=0.
- **Initialisation.** `ready` rises exactly `DEPTH` edges after the first edge with `rst`=0 (64 cycles at default).
- **Load latency.** A load accepted at edge N produces `dvalid`/`dout`/`err` valid after edge N+1, for one cycle.
- **Throughput.** Back-to-back loads give one result per cycle.
- **Store latency.** A store accepted at edge N is visible to a load accepted at edge N+1.
- **No stall after init.** `ready` never drops in RUN; only `rst` returns the block to INIT.

## Test plan
All scenarios use default parameters.

1. **Init and clear.** Hold `rst` 2 cycles, then release → `ready`=0 for exactly 64 cycles, then 1. A word load at 0x50 → next cycle `dvalid`=1, `dout`=0x00000000, `err`=0.
2. **Word round trip.** Store word 0x000000a3 at 0x50, then load 0x50 the next cycle → `dout`=0x000000a3. Back-to-back loads of 0x50, 0x54 → results on consecutive cycles.
3. **Byte lanes and extension.**
   - Store word 0x00000027 at 0x54, then store byte 0x81 at 0x55.
   - Word load 0x54 → 0x00008127.
   - Byte load 0x55 with `sext`=1 → 0xFFFFFF81; with `sext`=0 → 0x00000081.
   - Half load 0x54 with `sext`=1 → 0xFFFF8127.
4. **Misalignment.**
   - Half store 0x1234 at 0x5B → next cycle `dvalid`=1, `err`=1, `dout`=0; word 0x58 unchanged.
   - Word load at 0x5A → `err`=1.
   - `size`=3 at 0x58 → `err`=1.
5. **Wrap-around.** Store word 0x00000079 at 0x158, then load 0x58 → 0x00000079. Store 0x00000115 at 0xFC, then load 0x1FC → 0x00000115.
6. **Reset mid-operation.** Accept a load of 0x50 (holding 0xa3) and assert `rst` at the next edge → `dvalid` stays 0 and `ready` is low for 64 cycles after release. A load of 0x50 then returns 0.
